// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (unsigned / two's-complement) with start/busy/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [2*N:0] acc, acc_next, prod_full;
  logic [N:0]   sum;
  logic [N-1:0] mcand, mplier, mplier_next;
  logic [CW-1:0] cnt;
  logic          neg;
  logic          last;

  // One iteration: add multiplicand into the upper half (carry kept), then shift right.
  always_comb begin
    sum         = acc[2*N:N] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next    = {sum, acc[N-1:0]} >> 1;
    mplier_next = mplier >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Remaining iterations would only shift, so apply them all at once.
    last      = (mplier_next == '0) || (cnt == CW'(N-1));
    prod_full = acc_next >> (CW'(N-1) - cnt);
`else
    last      = (cnt == CW'(N-1));
    prod_full = acc_next;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= (signed_mode && a[N-1]) ? (~a + 1'b1) : a;
            mplier <= (signed_mode && b[N-1]) ? (~b + 1'b1) : b;
            neg    <= signed_mode & (a[N-1] ^ b[N-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          if (last) p <= (2*N)'(neg ? (~prod_full + 1'b1) : prod_full);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=8): vector table, randomized ops against an arithmetic model, handshake corner cases.
module tb_seq_multiplier;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          busy;
  logic          done;
  logic [2*N-1:0] p;

  int total = 0;
  int bad = 0;

  seq_multiplier #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done), .p(p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sm;
    logic [15:0] exp_p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input bit sm);
    longint sx, sy;
    sx = sm ? longint'($signed(x)) : longint'(x);
    sy = sm ? longint'($signed(y)) : longint'(y);
    return 16'(sx * sy);
  endfunction

  function automatic int exp_lat(input logic [7:0] y, input bit sm);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [7:0] m;
    int hi;
    m = y;
    if (sm && y[7]) m = ~y + 8'd1;
    hi = 0;
    for (int i = 0; i < 8; i++) if (m[i]) hi = i + 1;
    return (hi < 1) ? 1 : hi;
`else
    if (sm && y[7]) return N;
    return N;
`endif
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 0, 1);
  endtask

  // scramble: keep start high and change operands during CALC
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input bit sm, input bit scramble,
                        output logic [15:0] rp, output int lat);
    bit got, busy_bad;
    wait_idle();
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      a = 8'($urandom); b = 8'($urandom); signed_mode = ~sm;
    end else begin
      start = 1'b0;
    end
    got = 0; busy_bad = 0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (!busy) busy_bad = 1;
      @(posedge clk); #1;
      lat = k;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
    check("busy_in_calc", 32'(busy_bad), 0);
    check("busy_at_done", 32'(busy), 0);
    rp = p;
  endtask

  initial begin
    vec_t vt[9];
    logic [15:0] rp, p0;
    int lat, ndone, exp_done, last_k, period, d;
    logic [7:0] ra, rb;
    bit rsm;

    vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vt[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vt[2] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vt[3] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    vt[4] = '{8'hFF, 8'h00, 1'b1, 16'h0000};
    vt[5] = '{8'h00, 8'd200, 1'b0, 16'h0000};
    vt[6] = '{8'd7, 8'd1, 1'b0, 16'd7};
    vt[7] = '{8'd9, 8'h20, 1'b0, 16'd288};
    vt[8] = '{8'h5A, 8'h00, 1'b0, 16'h0000};

    #3;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_p", 32'(p), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sm, 1'b0, rp, lat);
      check($sformatf("vec%0d_p", i), 32'(rp), 32'(vt[i].exp_p));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vt[i].b, vt[i].sm)));
    end

    // done is one cycle wide and p holds afterwards
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, rp, lat);
    p0 = rp;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check("p_hold", 32'(p), 32'h0000FE01);
    check("p_hold_same", 32'(p), 32'(p0));

    // operands and start changing during CALC do not affect the result
    run_op(8'd3, 8'd4, 1'b0, 1'b1, rp, lat);
    check("scramble_p", 32'(rp), 12);
    check("scramble_lat", 32'(lat), 32'(exp_lat(8'd4, 1'b0)));

    // start held high continuously: one op per (latency + 2) cycles
    wait_idle();
    a = 8'd3; b = 8'd4; signed_mode = 1'b0; start = 1'b1;
    ndone = 0; last_k = -1;
    period = exp_lat(8'd4, 1'b0) + 2;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("held_p", 32'(p), 12);
        if (last_k >= 0) check("held_period", 32'(k - last_k), 32'(period));
        last_k = k;
      end
    end
    start = 1'b0;
    exp_done = 0;
    d = 1 + exp_lat(8'd4, 1'b0);
    while (d <= 40) begin
      exp_done++;
      d += period;
    end
    check("held_count", 32'(ndone), 32'(exp_done));

    // asynchronous reset mid-operation
    wait_idle();
    a = 8'd10; b = 8'd10; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    check("async_p", 32'(p), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("no_done_after_reset", 32'(ndone), 0);
    run_op(8'd10, 8'd10, 1'b0, 1'b0, rp, lat);
    check("post_reset_p", 32'(rp), 100);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 5 == 0) rb = 8'(1 << $urandom_range(0, 7));
      rsm = 1'($urandom_range(0, 1));
      run_op(ra, rb, rsm, 1'b0, rp, lat);
      check($sformatf("rand%0d_p a=%0h b=%0h s=%0d", i, ra, rb, rsm), 32'(rp), 32'(ref_mul(ra, rb, rsm)));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(exp_lat(rb, rsm)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier.
- Computes a*b, unsigned or two's-complement signed, over multiple clock cycles using a single N-bit adder.
- Uses a start/busy/done handshake.
- Replaces the unrolled combinational multiplier wherever area matters more than latency.
- Consumed by datapath blocks that issue one multiply at a time and wait for done.

Parameters:
- N, 8, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new multiply; sampled only in IDLE.
- a  input  N  multiplicand; sampled at the accepting edge.
- b  input  N  multiplier; sampled at the accepting edge.
- signed_mode  input  1  1 = operands and product are two's complement, 0 = unsigned; sampled at the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; p is valid and new.
- p  output  2N  product register; holds its value until the next completion.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (async, any state):
  - state=IDLE; busy=0, done=0, p=0.
  - Internal accumulator, shift registers, counter and sign flag cleared.
  - Reset mid-operation abandons the operation; no done is issued.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1, latch operands and go to CALC; busy=1 from the next cycle.
  - Operand latching:
    - signed_mode=1: store |a| and |b| as N-bit unsigned magnitudes (|-2^(N-1)| = 2^(N-1) fits), and store neg = a[N-1] XOR b[N-1].
    - signed_mode=0: store a and b as-is, neg=0.
  - Clear accumulator and iteration counter.
- CALC, one iteration per cycle:
  - If the current multiplier LSB is 1, add the multiplicand into the upper half of the 2N+1-bit accumulator (carry kept).
  - Shift accumulator right 1; shift multiplier right 1; counter increments.
  - After the N-th iteration (edge t0+N, where t0 is the accepting edge), write p and go to DONE.
  - p = neg ? two's-complement negation (2N bits) of the magnitude product : magnitude product.
- DONE:
  - done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
  - start is ignored in DONE; a new operation is accepted no earlier than the cycle after done.
- Latency: done is high in the cycle following edge t0+N, i.e. N cycles after acceptance. Throughput is one operation per N+2 cycles.
- start is ignored while busy; operand inputs may change freely after the accepting edge.
- p changes only at completion or reset.
- Boundary results:
  - Zero operand gives p=0 with no negative zero: a neg result of magnitude 0 yields 0.
  - Unsigned max: (2^N-1)^2 fits in 2N bits.
  - Signed min*min = 2^(2N-2) is positive and fits.
  - Signed min*1 = -2^(N-1), sign-extended to 2N bits.
- signed_mode is ignored except at the accepting edge.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - CALC ends at the first edge where the multiplier shift register becomes zero after shifting.
  - The accumulator is aligned by shifting right by the remaining iteration count, so p equals the N-iteration result.
  - Latency is max(1, index of highest set bit of |b| + 1) cycles; b=0 completes in 1 cycle.
- Not defined: fixed N-cycle latency, as above.
- The handshake, reset and result values are identical in both builds.

Test Plan:
- N=8, unsigned, a=255, b=255, start pulse -> busy=1 for 8 cycles, done pulse in cycle 9 after acceptance, p=0xFE01; p holds afterwards.
- N=8, signed, a=0x80 (-128), b=0x80 -> p=0x4000; a=0xFD (-3), b=0x05 -> p=0xFFF1 (-15); a=0x80, b=0x01 -> p=0xFF80.
- N=8, start held high continuously with a=3, b=4 -> exactly one op per 10 cycles, each done pulse with p=12; start during CALC/DONE not accepted; changing a/b mid-CALC does not alter p.
- N=8, signed, a=0xFF (-1), b=0x00 -> p=0x0000; unsigned a=0, b=200 -> p=0.
- Assert reset 4 cycles into an op (a=10, b=10) -> busy, done and p go to 0 immediately without waiting for clk; no done follows; a subsequent op with a=10, b=10 gives p=100.
- With SEQ_MULT_EARLY_TERM_EN, N=8: a=7, b=1 -> done after 1 cycle, p=7; a=9, b=0x20 -> done after 6 cycles, p=288; b=0 -> done after 1 cycle, p=0. Without the macro, all cases take 8 cycles with the same p.
